// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the single register-file write port (EXU vs LSU), with a
// one-stage registered write buffer and a pending-write scoreboard for RAW detection.
module regfile_wb_arbiter #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  exu_valid,
  output logic                  exu_ready,
  input  logic [ADDR_WIDTH-1:0] exu_rd,
  input  logic [DATA_WIDTH-1:0] exu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  input  logic                  iss_set,
  input  logic [ADDR_WIDTH-1:0] iss_rd,
  input  logic [ADDR_WIDTH-1:0] chk_rs1,
  input  logic [ADDR_WIDTH-1:0] chk_rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_rd,
  output logic [DATA_WIDTH-1:0] rf_data
);

  localparam int              NUM_REGS   = 1 << ADDR_WIDTH;
  localparam logic [3:0]      STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [ADDR_WIDTH-1:0] REG_ZERO = {ADDR_WIDTH{1'b0}};

  logic                  exu_gnt_s;
  logic                  lsu_gnt_s;
  logic                  accept_s;
  logic [ADDR_WIDTH-1:0] win_rd_s;
  logic [DATA_WIDTH-1:0] win_data_s;

  logic [3:0]            starve_q, starve_d;
  logic                  rf_wen_q, rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_rd_q, rf_rd_d;
  logic [DATA_WIDTH-1:0] rf_data_q, rf_data_d;
  logic [NUM_REGS-1:0]   pending_q, pending_d;

  // Arbitration: LSU wins contention unless EXU has been starved STARVE_LIMIT times.
  always_comb begin
    exu_gnt_s = 1'b0;
    lsu_gnt_s = 1'b0;
    if (exu_valid && (!lsu_valid || (starve_q == STARVE_MAX))) begin
      exu_gnt_s = 1'b1;
    end else if (lsu_valid) begin
      lsu_gnt_s = 1'b1;
    end else begin
      exu_gnt_s = 1'b0;
      lsu_gnt_s = 1'b0;
    end
  end

  // Readies are forced low while reset is asserted, independent of the clock.
  assign exu_ready = exu_gnt_s & rst_n;
  assign lsu_ready = lsu_gnt_s & rst_n;
  assign accept_s  = exu_gnt_s | lsu_gnt_s;

  // Winner select feeding the output buffer.
  always_comb begin
    win_rd_s   = lsu_rd;
    win_data_s = lsu_data;
    if (exu_gnt_s) begin
      win_rd_s   = exu_rd;
      win_data_s = exu_data;
    end else begin
      win_rd_s   = lsu_rd;
      win_data_s = lsu_data;
    end
  end

  // Starve counter: counts contested EXU losses, cleared by any EXU grant.
  always_comb begin
    starve_d = starve_q;
    if (exu_gnt_s) begin
      starve_d = 4'd0;
    end else if (exu_valid && lsu_gnt_s && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + 4'd1;
    end else begin
      starve_d = starve_q;
    end
  end

  // Output buffer next state; x0 writes are accepted but never reach the register file.
  always_comb begin
    rf_wen_d  = accept_s && (win_rd_s != REG_ZERO);
    rf_rd_d   = rf_rd_q;
    rf_data_d = rf_data_q;
    if (rf_wen_d) begin
      rf_rd_d   = win_rd_s;
      rf_data_d = win_data_s;
    end else begin
      rf_rd_d   = rf_rd_q;
      rf_data_d = rf_data_q;
    end
  end

  // Scoreboard next state: clear on commit, then set on issue so a same-edge set wins.
  always_comb begin
    pending_d = pending_q;
    if (rf_wen_q) begin
      pending_d[rf_rd_q] = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    if (iss_set && (iss_rd != REG_ZERO)) begin
      pending_d[iss_rd] = 1'b1;
    end else begin
      pending_d[0] = 1'b0;
    end
    pending_d[0] = 1'b0;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q  <= 4'd0;
      rf_wen_q  <= 1'b0;
      rf_rd_q   <= REG_ZERO;
      rf_data_q <= {DATA_WIDTH{1'b0}};
      pending_q <= {NUM_REGS{1'b0}};
    end else begin
      starve_q  <= starve_d;
      rf_wen_q  <= rf_wen_d;
      rf_rd_q   <= rf_rd_d;
      rf_data_q <= rf_data_d;
      pending_q <= pending_d;
    end
  end

  assign rf_wen   = rf_wen_q;
  assign rf_rd    = rf_rd_q;
  assign rf_data  = rf_data_q;
  assign rs1_busy = pending_q[chk_rs1];
  assign rs2_busy = pending_q[chk_rs2];

endmodule
